// File: rtl/fazyrv_rf_pkg.sv
// Shared definitions for the FazyRV logic register file: chunk geometry
// helpers, parameter legality predicates and the latched address bundle.
package fazyrv_rf_pkg;

    // Number of chunks that make up one 32-bit word.
    function automatic int unsigned nchunk(input int unsigned cs);
        return 32 / cs;
    endfunction

    // Width of the chunk counter (at least one bit, even for 32-bit chunks).
    function automatic int unsigned cntw(input int unsigned cs);
        return ((32 / cs) > 1) ? $clog2(32 / cs) : 1;
    endfunction

    function automatic bit legal_chunksize(input int unsigned cs);
        return (cs == 1) || (cs == 2) || (cs == 4) || (cs == 8) || (cs == 16) || (cs == 32);
    endfunction

    function automatic bit legal_nregs(input int unsigned n);
        return (n == 32) || (n == 16);
    endfunction

    function automatic bit legal_shftsel(input int unsigned s);
        return (s == 0) || (s == 1);
    endfunction

    // Register addresses of the instruction currently being streamed.
    typedef struct packed {
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
    } rf_addr_t;

endpackage

// File: rtl/fazyrv_shftreg.sv
// One architectural register: a 32-bit rotating shift register that moves
// right by CHUNKSIZE per enabled cycle. The outgoing LSB chunk re-enters at
// the MSB unless a write supplies a new chunk. Storage is not reset.
module fazyrv_shftreg #(
    parameter int unsigned CHUNKSIZE = 2
)(
    input  logic                 clk_i,
    input  logic                 shft_i,
    input  logic                 we_i,
    input  logic [CHUNKSIZE-1:0] dat_i,
    output logic [31:0]          dat_o
);

    logic [31:0]          reg_q;
    logic [31:0]          reg_nxt;
    logic [CHUNKSIZE-1:0] in_chunk;

    // Select the chunk entering at the MSB and form the rotated word.
    always_comb begin
        in_chunk = we_i ? dat_i : reg_q[CHUNKSIZE-1:0];
        reg_nxt  = reg_q;
        if (CHUNKSIZE == 32) begin
            reg_nxt = 32'(in_chunk);
        end else begin
            reg_nxt = {in_chunk, reg_q[31:CHUNKSIZE]};
        end
    end

    // Advance the register by one chunk when enabled.
    always_ff @(posedge clk_i) begin
        if (shft_i) begin
            reg_q <= reg_nxt;
        end
    end

    assign dat_o = reg_q;

endmodule

// File: rtl/fazyrv_rf_lut_sel.sv
// Logic-based register file for FazyRV. Each register streams CHUNKSIZE bits
// per shift; a shared chunk counter tracks the position within the word and
// latches the instruction's addresses at the start of every word.
module fazyrv_rf_lut_sel
    import fazyrv_rf_pkg::*;
#(
    parameter int unsigned CHUNKSIZE = 2,
    parameter int unsigned NREGS     = 32,
    parameter int unsigned SHFTSEL   = 1
)(
    input  logic                         clk_i,
    input  logic                         rst_in,
    input  logic                         shft_i,
    input  logic                         shft_rd_i,
    input  logic [4:0]                   rs1_i,
    input  logic [4:0]                   rs2_i,
    input  logic [4:0]                   rd_i,
    input  logic [CHUNKSIZE-1:0]         res_i,
    input  logic                         we_i,
    output logic [CHUNKSIZE-1:0]         ra_o,
    output logic [CHUNKSIZE-1:0]         rb_o,
    output logic [cntw(CHUNKSIZE)-1:0]   cnt_o,
    output logic                         word_done_o,
    output logic                         aligned_o,
    input  logic [4:0]                   dbg_addr_i,
    output logic [31:0]                  dbg_dat_o
);

    localparam int unsigned     NCHUNK   = nchunk(CHUNKSIZE);
    localparam int unsigned     CNTW     = cntw(CHUNKSIZE);
    localparam logic [CNTW-1:0] CNT_LAST = CNTW'(NCHUNK - 1);

    if (!legal_chunksize(CHUNKSIZE)) begin : g_bad_chunksize
        $error("fazyrv_rf_lut_sel: CHUNKSIZE must be 1, 2, 4, 8, 16 or 32");
    end
    if (!legal_nregs(NREGS)) begin : g_bad_nregs
        $error("fazyrv_rf_lut_sel: NREGS must be 16 or 32");
    end
    if (!legal_shftsel(SHFTSEL)) begin : g_bad_shftsel
        $error("fazyrv_rf_lut_sel: SHFTSEL must be 0 or 1");
    end

    logic [CNTW-1:0] cnt_q;
    logic            word_done_q;
    logic            aligned;
    logic            wrap;
    rf_addr_t        addr_q;
    rf_addr_t        addr_live;
    rf_addr_t        addr_eff;

    logic [NREGS-1:1] sh_en;
    logic [NREGS-1:1] wr_en;
    logic [31:0]      reg_q [32];

    // Address that exists in this configuration and is not the zero register.
    function automatic logic addr_ok(input logic [4:0] a);
        return (a != 5'd0) && ((NREGS == 32) || !a[4]);
    endfunction

    assign aligned   = (cnt_q == '0);
    assign wrap      = (cnt_q == CNT_LAST);
    assign addr_live = '{rs1: rs1_i, rs2: rs2_i, rd: rd_i};

    // Live addresses apply on the first chunk; the latched copy holds for the rest.
    always_comb begin
        addr_eff = aligned ? addr_live : addr_q;
    end

    // Chunk counter, word-done pulse and per-word address latch.
    always_ff @(posedge clk_i) begin
        if (!rst_in) begin
            cnt_q       <= '0;
            word_done_q <= 1'b0;
            addr_q      <= '0;
        end else begin
            word_done_q <= shft_i && wrap;
            if (shft_i) begin
                cnt_q <= wrap ? '0 : cnt_q + CNTW'(1);
            end
            if (shft_i && aligned) begin
                addr_q <= addr_live;
            end
        end
    end

    // Per-register write and shift enables. OR-ing the match terms means an
    // aliased register still rotates only once, and shft_rd_i together with
    // shft_i on rd collapses into a single shift.
    always_comb begin
        sh_en = '0;
        wr_en = '0;
        for (int unsigned r = 1; r < NREGS; r++) begin
            wr_en[r] = we_i && addr_ok(addr_eff.rd) && (addr_eff.rd == 5'(r));
            sh_en[r] = ((SHFTSEL == 0) ? shft_i
                                       : (shft_i && ((addr_eff.rs1 == 5'(r)) ||
                                                     (addr_eff.rs2 == 5'(r)) ||
                                                     (addr_eff.rd  == 5'(r)))))
                       || (shft_rd_i && wr_en[r]);
        end
    end

    // x0 and registers absent in the reduced configuration read as zero.
    assign reg_q[0] = '0;
    for (genvar r = 1; r < 32; r++) begin : g_reg
        if (r < NREGS) begin : g_phys
            fazyrv_shftreg #(
                .CHUNKSIZE (CHUNKSIZE)
            ) u_reg (
                .clk_i  (clk_i),
                .shft_i (sh_en[r]),
                .we_i   (wr_en[r]),
                .dat_i  (res_i),
                .dat_o  (reg_q[r])
            );
        end else begin : g_absent
            assign reg_q[r] = '0;
        end
    end

    assign ra_o        = reg_q[addr_eff.rs1][CHUNKSIZE-1:0];
    assign rb_o        = reg_q[addr_eff.rs2][CHUNKSIZE-1:0];
    assign dbg_dat_o   = reg_q[dbg_addr_i];
    assign cnt_o       = cnt_q;
    assign aligned_o   = aligned;
    assign word_done_o = word_done_q;

endmodule

// File: tb/tb_fazyrv_rf_lut_sel.sv
// Self-checking bench for fazyrv_rf_lut_sel. Two instances share stimulus:
// u_a (CHUNKSIZE=2, NREGS=32, SHFTSEL=0) and u_b (CHUNKSIZE=2, NREGS=16, SHFTSEL=1).
module tb_fazyrv_rf_lut_sel;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        shft, shft_rd, we;
    logic [4:0]  rs1, rs2, rd, dbg_addr;
    logic [1:0]  res;

    logic [1:0]  ra_a, rb_a, ra_b, rb_b;
    logic [3:0]  cnt_a, cnt_b;
    logic        done_a, done_b, al_a, al_b;
    logic [31:0] dbg_a, dbg_b;

    always #5 clk = ~clk;

    fazyrv_rf_lut_sel #(.CHUNKSIZE(2), .NREGS(32), .SHFTSEL(0)) u_a (
        .clk_i(clk), .rst_in(rst_n), .shft_i(shft), .shft_rd_i(shft_rd),
        .rs1_i(rs1), .rs2_i(rs2), .rd_i(rd), .res_i(res), .we_i(we),
        .ra_o(ra_a), .rb_o(rb_a), .cnt_o(cnt_a), .word_done_o(done_a),
        .aligned_o(al_a), .dbg_addr_i(dbg_addr), .dbg_dat_o(dbg_a)
    );

    fazyrv_rf_lut_sel #(.CHUNKSIZE(2), .NREGS(16), .SHFTSEL(1)) u_b (
        .clk_i(clk), .rst_in(rst_n), .shft_i(shft), .shft_rd_i(shft_rd),
        .rs1_i(rs1), .rs2_i(rs2), .rd_i(rd), .res_i(res), .we_i(we),
        .ra_o(ra_b), .rb_o(rb_b), .cnt_o(cnt_b), .word_done_o(done_b),
        .aligned_o(al_b), .dbg_addr_i(dbg_addr), .dbg_dat_o(dbg_b)
    );

    typedef enum {O_CNT_A, O_DONE_A, O_AL_A, O_CNT_B, O_DONE_B, O_AL_B,
                  O_RA_A, O_RB_A, O_RA_B, O_RB_B, O_DBG_A, O_DBG_B} obs_t;

    typedef struct {
        obs_t        obs;
        logic [31:0] exp;
        logic [31:0] mask;
        string       tag;
    } exp_t;

    typedef struct {
        bit          shft;
        int unsigned cnt;
        bit          done;
        bit          al;
    } cvec_t;

    exp_t  sbq[$];
    cvec_t tbl[18];
    int    checks   = 0;
    int    failures = 0;

    localparam logic [31:0] W_DB = 32'hDEADBEEF;
    localparam logic [31:0] W_12 = 32'h12345678;
    localparam logic [31:0] W_12_ROT1 = 32'h048D159E;

    function automatic logic [1:0] chunk(input logic [31:0] w, input int k);
        return w[2*k +: 2];
    endfunction

    function automatic logic [31:0] actual(input obs_t o);
        case (o)
            O_CNT_A:  return {28'd0, cnt_a};
            O_DONE_A: return {31'd0, done_a};
            O_AL_A:   return {31'd0, al_a};
            O_CNT_B:  return {28'd0, cnt_b};
            O_DONE_B: return {31'd0, done_b};
            O_AL_B:   return {31'd0, al_b};
            O_RA_A:   return {30'd0, ra_a};
            O_RB_A:   return {30'd0, rb_a};
            O_RA_B:   return {30'd0, ra_b};
            O_RB_B:   return {30'd0, rb_b};
            O_DBG_A:  return dbg_a;
            default:  return dbg_b;
        endcase
    endfunction

    task automatic push(input obs_t o, input logic [31:0] v, input string tag,
                        input logic [31:0] mask = 32'hFFFFFFFF);
        exp_t e;
        e.obs = o; e.exp = v; e.mask = mask; e.tag = tag;
        sbq.push_back(e);
    endtask

    task automatic drive(input bit s, input bit srd, input logic [4:0] a1,
                         input logic [4:0] a2, input logic [4:0] d,
                         input logic [1:0] r, input bit w, input logic [4:0] da);
        shft = s; shft_rd = srd; rs1 = a1; rs2 = a2; rd = d;
        res = r; we = w; dbg_addr = da;
    endtask

    // Let combinational outputs settle, then drain the scoreboard.
    task automatic observe();
        exp_t        e;
        logic [31:0] act;
        #2;
        while (sbq.size() > 0) begin
            e   = sbq.pop_front();
            act = actual(e.obs);
            checks++;
            if ((act & e.mask) !== (e.exp & e.mask)) begin
                failures++;
                $display("FAIL %s: got %h expected %h (mask %h)", e.tag, act, e.exp, e.mask);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic [4:0] da);
        drive(0, 0, 5'd0, 5'd0, 5'd0, 2'd0, 0, da);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) tbl[i] = '{1'b1, i, 1'b0, (i == 0)};
        tbl[16] = '{1'b0, 0, 1'b1, 1'b1};
        tbl[17] = '{1'b0, 0, 1'b0, 1'b1};

        rst_n = 1'b0;
        idle(5'd0);
        tick(); tick();
        rst_n = 1'b1;

        // Reset state
        idle(5'd0);
        push(O_CNT_A, 0, "rst_cnt_a"); push(O_AL_A, 1, "rst_al_a");
        push(O_DONE_A, 0, "rst_done_a"); push(O_CNT_B, 0, "rst_cnt_b");
        push(O_AL_B, 1, "rst_al_b"); push(O_RA_A, 0, "rst_ra_x0");
        observe();

        // Counter sweep over one word, no writes
        for (int i = 0; i < 18; i++) begin
            drive(tbl[i].shft, 0, 5'd0, 5'd0, 5'd0, 2'd0, 0, 5'd0);
            push(O_CNT_A, tbl[i].cnt, "sweep_cnt_a");
            push(O_DONE_A, tbl[i].done, "sweep_done_a");
            push(O_AL_A, tbl[i].al, "sweep_al_a");
            push(O_CNT_B, tbl[i].cnt, "sweep_cnt_b");
            push(O_DONE_B, tbl[i].done, "sweep_done_b");
            observe();
            tick();
        end

        // Write 0xDEADBEEF to x5, LSB chunk first
        for (int k = 0; k < 16; k++) begin
            drive(1, 0, 5'd0, 5'd0, 5'd5, chunk(W_DB, k), 1, 5'd5);
            if (k == 1) push(O_DBG_A, 32'hC0000000, "wr_msb_chunk", 32'hC0000000);
            observe();
            tick();
        end
        idle(5'd5);
        push(O_DBG_A, W_DB, "wr_x5_a"); push(O_DBG_B, W_DB, "wr_x5_b");
        push(O_DONE_A, 1, "wr_done_a"); push(O_AL_A, 1, "wr_al_a");
        observe();
        tick();

        // Read x5; rs1 switches to x9 at cnt=4 and must be ignored mid-word
        for (int k = 0; k < 16; k++) begin
            drive(1, 0, (k < 4) ? 5'd9 - 5'd4 : 5'd9, 5'd5, 5'd0, 2'd0, 0, 5'd5);
            push(O_RA_A, chunk(W_DB, k), "rd_ra_a");
            push(O_RB_A, chunk(W_DB, k), "rd_rb_a");
            push(O_RA_B, chunk(W_DB, k), "rd_ra_b");
            observe();
            tick();
        end
        idle(5'd5);
        push(O_DBG_A, W_DB, "rd_x5_after_a"); push(O_DBG_B, W_DB, "rd_x5_after_b");
        observe();
        tick();

        // shft_rd_i alone, then together with shft_i, on x3
        drive(0, 1, 5'd0, 5'd0, 5'd3, 2'b01, 1, 5'd3);
        observe();
        tick();
        idle(5'd3);
        push(O_CNT_A, 0, "shftrd_cnt");
        push(O_DBG_A, 32'h40000000, "shftrd_msb", 32'hC0000000);
        observe();
        drive(1, 1, 5'd0, 5'd0, 5'd3, 2'b10, 1, 5'd3);
        observe();
        tick();
        idle(5'd3);
        push(O_CNT_A, 1, "both_cnt");
        push(O_DBG_A, 32'h90000000, "both_single_shift", 32'hF0000000);
        observe();
        for (int k = 1; k < 16; k++) begin
            drive(1, 0, 5'd0, 5'd0, 5'd3, 2'd0, 0, 5'd3);
            tick();
        end
        idle(5'd3);
        push(O_AL_A, 1, "both_realigned");
        observe();

        // Preload x7 = 0x12345678
        for (int k = 0; k < 16; k++) begin
            drive(1, 0, 5'd0, 5'd0, 5'd7, chunk(W_12, k), 1, 5'd7);
            tick();
        end
        idle(5'd7);
        push(O_DBG_A, W_12, "pre_x7_a"); push(O_DBG_B, W_12, "pre_x7_b");
        observe();

        // Word on rs1=1, rs2=2, rd=3: unaddressed x7 holds still only with SHFTSEL=1
        for (int k = 0; k < 16; k++) begin
            drive(1, 0, 5'd1, 5'd2, 5'd3, 2'd0, 0, 5'd7);
            push(O_DBG_B, W_12, "sel_x7_hold_b");
            if (k == 1) push(O_DBG_A, W_12_ROT1, "nosel_x7_rot_a");
            observe();
            tick();
        end

        // Aliased rs1=rs2=rd=7: one rotation per shift
        for (int k = 0; k < 16; k++) begin
            drive(1, 0, 5'd7, 5'd7, 5'd7, 2'd0, 0, 5'd7);
            if (k == 1) push(O_DBG_B, W_12_ROT1, "alias_rot_once_b");
            observe();
            tick();
        end
        idle(5'd7);
        push(O_DBG_B, W_12, "alias_word_b");
        observe();

        // Write rd=20 with all ones: dropped on the 16-register instance
        for (int k = 0; k < 16; k++) begin
            drive(1, 0, 5'd0, 5'd0, 5'd20, 2'b11, 1, 5'd20);
            tick();
        end
        idle(5'd20);
        push(O_DBG_A, 32'hFFFFFFFF, "x20_a"); push(O_DBG_B, 32'h0, "x20_b");
        observe();
        idle(5'd5);
        push(O_DBG_B, W_DB, "x20_x5_b");
        observe();
        idle(5'd7);
        push(O_DBG_B, W_12, "x20_x7_b");
        observe();
        drive(0, 0, 5'd20, 5'd20, 5'd0, 2'd0, 0, 5'd0);
        push(O_RA_B, 0, "rd20_ra_b"); push(O_RB_B, 0, "rd20_rb_b");
        push(O_RA_A, 3, "rd20_ra_a");
        observe();
        tick();

        // Write to x0 is dropped
        for (int k = 0; k < 16; k++) begin
            drive(1, 0, 5'd0, 5'd0, 5'd0, 2'b11, 1, 5'd0);
            tick();
        end
        idle(5'd0);
        push(O_DBG_A, 0, "x0_a"); push(O_DBG_B, 0, "x0_b");
        push(O_RA_A, 0, "x0_ra_a");
        observe();

        // Reset asserted mid-word at cnt=7
        for (int k = 0; k < 7; k++) begin
            drive(1, 0, 5'd5, 5'd5, 5'd0, 2'd0, 0, 5'd0);
            tick();
        end
        drive(1, 0, 5'd5, 5'd5, 5'd0, 2'd0, 0, 5'd0);
        push(O_CNT_A, 7, "pre_rst_cnt");
        observe();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        idle(5'd0);
        push(O_CNT_A, 0, "midrst_cnt_a"); push(O_AL_A, 1, "midrst_al_a");
        push(O_DONE_A, 0, "midrst_done_a"); push(O_CNT_B, 0, "midrst_cnt_b");
        push(O_AL_B, 1, "midrst_al_b");
        observe();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
